// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package cpu_pkg;

  localparam int WORD_W         = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int NUM_LINES_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Data, tag and valid storage for icache_fetch: one combinational read port,
// one word write port, per-line tag set / valid clear, and a global valid clear.
module icache_array
  import cpu_pkg::*;
#(
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  parameter  int NUM_LINES  = NUM_LINES_DEF,
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int TAG_W      = WORD_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              line_set_i,
  input  logic              line_clr_i,
  input  logic [IDX_W-1:0]  line_idx_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic              clr_all_i
);

  logic [WORD_W-1:0]    data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Data and tags carry no reset; the valid bits alone gate every hit.
  always_ff @(posedge clk) begin
    if (wr_en_i)    data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (line_set_i) tag_q[line_idx_i]          <= line_tag_i;
  end

  // A global clear wins over setting the line, so an invalidate that lands
  // during a fill also drops the freshly filled line.
  always_ff @(posedge clk) begin
    if (rst || clr_all_i)  valid_q             <= '0;
    else if (line_set_i)   valid_q[line_idx_i] <= 1'b1;
    else if (line_clr_i)   valid_q[line_idx_i] <= 1'b0;
  end

  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: combinational hits, blocking line
// fills from main memory. Optional hit/miss counters under `ICACHE_STATS_EN.
//
// state | meaning
// IDLE  | lookup; hit returns instr same cycle, miss starts a fill
// FILL  | fetch the whole line word by word; cannot be aborted
module icache_fetch
  import cpu_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [WORD_W-1:0] addr,
  input  logic              inv,
  output logic [WORD_W-1:0] instr,
  output logic              stall,
  output logic              mem_re,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rdy
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  icache_state_t    state_q, state_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [OFF_W-1:0] wcnt_q, wcnt_d;
  logic             inv_pend_q, inv_pend_d;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [OFF_W-1:0]  a_off;
  logic [WORD_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;

  logic              wr_en;
  logic              line_set;
  logic              line_clr;
  logic [IDX_W-1:0]  line_idx;
  logic              clr_all;
  logic              miss_start;

  assign a_tag = addr[WORD_W-1:IDX_W+OFF_W];
  assign a_idx = addr[IDX_W+OFF_W-1:OFF_W];
  assign a_off = addr[OFF_W-1:0];
  assign hit   = re & rd_valid & (rd_tag == a_tag);

  icache_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (a_idx),
    .rd_off_i   (a_off),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .wr_en_i    (wr_en),
    .wr_idx_i   (fill_idx_q),
    .wr_off_i   (wcnt_q),
    .wr_data_i  (mem_rdata),
    .line_set_i (line_set),
    .line_clr_i (line_clr),
    .line_idx_i (line_idx),
    .line_tag_i (fill_tag_q),
    .clr_all_i  (clr_all)
  );

  always_comb begin
    state_d    = state_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    wcnt_d     = wcnt_q;
    inv_pend_d = inv_pend_q;
    instr      = '0;
    stall      = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    wr_en      = 1'b0;
    line_set   = 1'b0;
    line_clr   = 1'b0;
    line_idx   = fill_idx_q;
    clr_all    = 1'b0;
    miss_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        clr_all  = inv;
        line_idx = a_idx;
        if (hit) begin
          instr = rd_data;
        end else if (re) begin
          stall      = 1'b1;
          miss_start = 1'b1;
          line_clr   = 1'b1;
          fill_tag_d = a_tag;
          fill_idx_d = a_idx;
          wcnt_d     = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = {fill_tag_q, fill_idx_q, wcnt_q};
        if (inv) inv_pend_d = 1'b1;
        if (mem_rdy) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_OFF) begin
            line_set   = 1'b1;
            clr_all    = inv_pend_q | inv;
            inv_pend_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset forces quiet outputs and blocks any array update.
    if (rst) begin
      instr      = '0;
      stall      = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      wr_en      = 1'b0;
      line_set   = 1'b0;
      line_clr   = 1'b0;
      clr_all    = 1'b0;
      miss_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      inv_pend_q <= inv_pend_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && hit && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_start && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: memory model returns 0xA000 + (addr - 0x10)
// with a configurable number of wait cycles before each word.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re  = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        inv = 1'b0;
  logic [15:0] instr;
  logic        stall;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rdy   = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          wait_cfg = 1;
  int          wait_cnt = 0;

  icache_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .addr      (addr),
    .inv       (inv),
    .instr     (instr),
    .stall     (stall),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'hA000 + (a - 16'h0010);
  endfunction

  // Memory responds shortly after each rising edge; accepted addresses are logged.
  always @(posedge clk) begin
    #2;
    if (mem_re === 1'b1) begin
      if (wait_cnt >= wait_cfg) begin
        mem_rdy   = 1'b1;
        mem_rdata = memf(mem_addr);
        obs_q.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_rdy  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_rdy  = 1'b0;
      wait_cnt = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic fetch(input logic [15:0] a, input bit exp_miss, input string nm,
                       output int stall_cyc);
    int n = 0;
    logic [15:0] e;
    obs_q.delete();
    @(negedge clk);
    re = 1'b1; addr = a; inv = 1'b0;
    exp_q.push_back(memf(a));
    #1;
    tests_run++;
    if (stall !== exp_miss) begin
      tests_failed++;
      $display("FAIL %s_first_stall: got %b want %b", nm, stall, exp_miss);
    end
    while (stall !== 1'b0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    stall_cyc = n;
    e = exp_q.pop_front();
    tests_run++;
    if (n >= 200 || instr !== e) begin
      tests_failed++;
      $display("FAIL %s_instr: got %h want %h (stall cycles %0d)", nm, instr, e, n);
    end
    tests_run++;
    if (mem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_mem_re_on_hit: got %b want 0", nm, mem_re);
    end
    if (exp_miss) begin
      tests_run++;
      if (obs_q.size() != 4) begin
        tests_failed++;
        $display("FAIL %s_fill_words: got %0d want 4", nm, obs_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          tests_run++;
          if (obs_q[i] !== ((a & 16'hFFFC) + 16'(i))) begin
            tests_failed++;
            $display("FAIL %s_mem_addr%0d: got %h want %h", nm, i, obs_q[i],
                     (a & 16'hFFFC) + 16'(i));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (stall !== 1'b0 || instr !== 16'h0 || mem_re !== 1'b0 || mem_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got stall=%b instr=%h mem_re=%b mem_addr=%h want 0/0000/0/0000",
               stall, instr, mem_re, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0; re = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0 || instr !== 16'h0 || mem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got stall=%b instr=%h mem_re=%b want 0/0000/0", stall, instr, mem_re);
    end
`ifdef ICACHE_STATS_EN
    tests_run++;
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %h/%h want 0000/0000", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_cold_miss();
    int n;
    wait_cfg = 1;
    fetch(16'h0012, 1'b1, "cold_miss", n);
    tests_run++;
    if (n - 1 != 8) begin
      tests_failed++;
      $display("FAIL cold_miss_fill_cycles: got %0d want 8", n - 1);
    end
  endtask

  task automatic test_line_hits();
    int n;
    for (int i = 0; i < 4; i++) fetch(16'h0010 + 16'(i), 1'b0, "line_hit", n);
  endtask

  task automatic test_conflict();
    int n;
    wait_cfg = 0;
    fetch(16'h0030, 1'b1, "conflict_new", n);
    tests_run++;
    if (n - 1 != 4) begin
      tests_failed++;
      $display("FAIL conflict_best_case_cycles: got %0d want 4", n - 1);
    end
    fetch(16'h0010, 1'b1, "conflict_evicted", n);
    wait_cfg = 1;
  endtask

  task automatic test_redirect();
    int n = 0;
    logic [15:0] e;
    obs_q.delete();
    @(negedge clk); re = 1'b1; addr = 16'h0040;
    @(negedge clk);
    @(negedge clk); addr = 16'h0045; exp_q.push_back(memf(16'h0045));
    #1;
    while (stall !== 1'b0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (n >= 200 || instr !== e) begin
      tests_failed++;
      $display("FAIL redirect_instr: got %h want %h", instr, e);
    end
    tests_run++;
    if (obs_q.size() != 8) begin
      tests_failed++;
      $display("FAIL redirect_words: got %0d want 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (obs_q[i] !== 16'h0040 + 16'(i)) begin
          tests_failed++;
          $display("FAIL redirect_mem_addr%0d: got %h want %h", i, obs_q[i], 16'h0040 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_inv_idle();
    int n = 0;
    logic [15:0] e;
    @(negedge clk); re = 1'b1; addr = 16'h0011; inv = 1'b1;
    exp_q.push_back(memf(16'h0011));
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (stall !== 1'b0 || instr !== e) begin
      tests_failed++;
      $display("FAIL inv_idle_same_cycle_hit: got stall=%b instr=%h want 0/%h", stall, instr, e);
    end
    @(negedge clk); inv = 1'b0;
    exp_q.push_back(memf(16'h0011));
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL inv_idle_next_miss: got stall=%b want 1", stall);
    end
    while (stall !== 1'b0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (n >= 200 || instr !== e) begin
      tests_failed++;
      $display("FAIL inv_idle_refill_instr: got %h want %h", instr, e);
    end
  endtask

  task automatic test_inv_fill();
    int n = 0;
    logic [15:0] e;
    obs_q.delete();
    @(negedge clk); re = 1'b1; addr = 16'h0052; exp_q.push_back(memf(16'h0052));
    @(negedge clk);
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    #1;
    while (stall !== 1'b0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (n >= 200 || instr !== e) begin
      tests_failed++;
      $display("FAIL inv_fill_instr: got %h want %h", instr, e);
    end
    tests_run++;
    if (obs_q.size() != 8) begin
      tests_failed++;
      $display("FAIL inv_fill_refetch_words: got %0d want 8", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    fetch(16'h0044, 1'b1, "pre_rst_fill", n);
    fetch(16'h0045, 1'b0, "pre_rst_hit", n);
    @(negedge clk); re = 1'b1; addr = 16'h0060;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_fill_start: got stall=%b want 1", stall);
    end
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0 || mem_re !== 1'b0 || instr !== 16'h0 || mem_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_held_outputs: got stall=%b mem_re=%b instr=%h mem_addr=%h want 0/0/0000/0000",
               stall, mem_re, instr, mem_addr);
    end
    @(negedge clk); rst = 1'b0; re = 1'b0;
    #1;
    tests_run++;
    if (mem_re !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_after_mem_re: got mem_re=%b stall=%b want 0/0", mem_re, stall);
    end
`ifdef ICACHE_STATS_EN
    tests_run++;
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_fill_stats: got %h/%h want 0000/0000", hit_cnt, miss_cnt);
    end
`endif
    fetch(16'h0045, 1'b1, "post_rst_miss", n);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_redirect();
    test_inv_idle();
    test_inv_fill();
    test_reset_mid_fill();
    @(negedge clk); re = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and multi-cycle main memory.
- Feeds the IF slice a 16-bit instruction for the current 16-bit word-addressed PC.
- On a hit, the instruction is returned combinationally in the same cycle.
- On a miss, the block stalls the pipeline and fills the whole line from memory, one word per handshake.

Parameters:
- LINE_WORDS, 4, words per line; power of 2, at least 2; OFF_W = log2(LINE_WORDS).
- NUM_LINES, 8, number of lines; power of 2; IDX_W = log2(NUM_LINES); TAG_W = 16 - IDX_W - OFF_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- re  in  1  fetch request from IF this cycle
- addr  in  16  PC, word address
- inv  in  1  invalidate all lines (pulse)
- instr  out  16  instruction; valid when re=1 and stall=0
- stall  out  1  miss or fill in progress; IF and ID must hold
- mem_re  out  1  main-memory read request
- mem_addr  out  16  main-memory word address
- mem_rdata  in  16  main-memory read data
- mem_rdy  in  1  mem_rdata valid for mem_addr this cycle

Behaviour:
- Address split: tag = addr[15:IDX_W+OFF_W], idx = addr[IDX_W+OFF_W-1:OFF_W], off = addr[OFF_W-1:0].
- Storage:
  - data array NUM_LINES x LINE_WORDS x 16;
  - tag array NUM_LINES x TAG_W;
  - valid array NUM_LINES x 1.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = re & valid[idx] & (tag_arr[idx] == tag).
  - On hit: instr = data[idx][off] combinationally, stall = 0.
  - On re with no hit: stall = 1 combinationally in the same cycle. Latch fill_tag and fill_idx from addr, clear wcnt, go to FILL.
  - re = 0: stall = 0, instr = 0x0000.
- FILL:
  - stall = 1 and mem_re = 1.
  - mem_addr = {fill_tag, fill_idx, wcnt}; instr = 0x0000.
  - On mem_rdy = 1: write mem_rdata into data[fill_idx][wcnt] and increment wcnt.
  - When the word with wcnt = LINE_WORDS-1 is accepted: write tag_arr[fill_idx] = fill_tag, set valid[fill_idx] = 1, go to IDLE.
  - mem_rdy may be high in the same cycle mem_re rises. Best case is therefore LINE_WORDS cycles in FILL.
  - Miss penalty is LINE_WORDS + total wait cycles; the hit is served on the first IDLE cycle after the fill.
- mem_re is 0 in IDLE; mem_addr is 0 in IDLE.
- Line replacement: the existing line at fill_idx is overwritten.
  - valid[fill_idx] is cleared on FILL entry so a partially filled line can never hit.
- addr or re changing during FILL (branch redirect, flush):
  - The fill always completes; it cannot be aborted.
  - Lookup then restarts in IDLE with the current addr.
- inv:
  - In IDLE: all valid bits clear at the next edge. A hit evaluated in the same cycle is still served from the pre-clear state.
  - During FILL: inv is latched in a pending flag. All valid bits, including the just-filled line, clear on the cycle FILL exits.
  - The pending flag is cleared at that point.
- Reset (rst = 1 at an edge, including mid-fill):
  - state = IDLE, wcnt = 0, all valid = 0, pending inv = 0.
  - Data and tag arrays are not reset.
- Outputs while rst is high: stall = 0, instr = 0x0000, mem_re = 0, mem_addr = 0.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds outputs hit_cnt [15:0] and miss_cnt [15:0]. Both reset to 0 on rst.
  - hit_cnt increments on each IDLE cycle with re & hit.
  - miss_cnt increments on each IDLE to FILL transition.
  - Both saturate at 0xFFFF.
- When undefined: no ports, no counters, no extra logic.

Decomposition:
- Shared package cpu_pkg (name fixed):
  - Word width constant WORD_W = 16.
  - Enum icache_state_t {IDLE, FILL}.
  - Default LINE_WORDS and NUM_LINES constants.
- One natural sub-module: icache_array, holding the data, tag and valid storage.
  - One combinational read port.
  - One word write port.
  - Tag/valid set and clear-all inputs.
- The FSM, address split and handshake live in icache_fetch.

Test Plan:
- Cold miss:
  - Stimulus: after rst, re = 1, addr = 0x0012; memory returns 0xA000+n for word n with one wait cycle per word.
  - Response: stall high the same cycle; mem_addr steps through 0x0010, 0x0011, 0x0012, 0x0013; stall low after 8 FILL cycles; instr = 0xA002.
- Line hits:
  - Stimulus: addr 0x0010 to 0x0013 on consecutive cycles after the fill.
  - Response: stall = 0 throughout; instr = 0xA000, 0xA001, 0xA002, 0xA003; mem_re stays 0.
- Conflict eviction:
  - Stimulus: fill 0x0010, then fetch 0x0030 (same idx 4, different tag).
  - Response: miss and refill; a later fetch of 0x0010 misses again.
- Redirect mid-fill:
  - Stimulus: during a fill of 0x0040, addr changes to 0x0045.
  - Response: the fill of 0x0040 to 0x0043 completes, then a new miss on 0x0045 fills 0x0044 to 0x0047.
- Invalidate:
  - Stimulus: inv pulse during FILL.
  - Response: after FILL exits, a fetch of the just-filled address misses.
  - Stimulus: inv pulse in IDLE.
  - Response: the next cycle's hit becomes a miss.
- Reset mid-fill:
  - Stimulus: rst asserted in the 2nd FILL cycle.
  - Response: mem_re = 0 the next cycle; state IDLE; all previous hits now miss. With ICACHE_STATS_EN: hit_cnt = miss_cnt = 0.
